sd_request_arbiter: RTL and testbench

Shares the single SD-card sector interface (`sd_lba` / `sd_rd` / `sd_wr` / `sd_busy` / `sd_done` / byte strobe) between up to NREQ requesters: the cartridge/PRG/ROM loader, the 1541 track buffer and spare slots. It sits between the SD card controller and those requesters. It grants one sector transaction at a time in round-robin order, steers the byte strobe and write data to and from the owner, and recovers from a controller that never accepts a request.

---
 rtl/sd_arb_pkg.sv | 29 ++
 rtl/rr_picker.sv | 25 ++
 rtl/sd_request_arbiter.sv | 141 ++++++++++++++
 tb/tb_sd_request_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-interface request arbiter.
package sd_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE,
        RELEASE
    } arb_state_t;

    // Sector operation latched at grant time
    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    // Cycles to wait for the controller to accept a request
    localparam int DEFAULT_ACCEPT_TIMEOUT = 1_000_000;

    // Width of the saturating acceptance-timeout counter
    localparam int TCNT_W = 32;

    // Next index after idx, wrapping modulo n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: returns the first set request
// at or after ptr, wrapping modulo N. Also used by the track-buffer port arbiter.
module rr_picker #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = W'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_request_arbiter.sv
// Round-robin arbiter sharing one SD-card sector interface between NREQ
// requesters. One sector transaction at a time; the byte strobe and write
// data are steered to/from the current owner, and a request the controller
// never accepts is abandoned after ACCEPT_TIMEOUT cycles.
module sd_request_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int ACCEPT_TIMEOUT = DEFAULT_ACCEPT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ*32-1:0]        req_lba,
    input  logic [NREQ-1:0]           req_rd,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [NREQ*8-1:0]         req_wr_data,
    output logic [NREQ-1:0]           req_busy,
    output logic [NREQ-1:0]           req_done,
    output logic [NREQ-1:0]           req_rd_strobe,
    output logic [31:0]               sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_busy,
    input  logic                      sd_done,
    input  logic                      sd_rd_byte_strobe,
    input  logic [8:0]                sd_byte_index,
    output logic [7:0]                sd_wr_data,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      timeout_err
);

    localparam int OW = $clog2(NREQ);
    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(ACCEPT_TIMEOUT - 1);

    arb_state_t        state;
    logic [OW-1:0]     rr_ptr;
    logic [TCNT_W-1:0] tcnt;

    logic [NREQ-1:0]   pending;
    logic [OW-1:0]     pick_idx;
    logic              pick_valid;
    arb_op_t           pick_op;
    logic [OW-1:0]     next_ptr;

    // The byte index is consumed by the requesters directly, not here
    logic unused_byte_index;
    assign unused_byte_index = ^sd_byte_index;

    assign pending  = req_rd | req_wr;
    assign next_ptr = OW'(wrap_inc(int'(owner), NREQ));

    rr_picker #(
        .N (NREQ),
        .W (OW)
    ) u_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    // Read wins when one requester asks for both; its write waits for a later grant
    always_comb begin
        pick_op = req_rd[pick_idx] ? OP_RD : OP_WR;
    end

    // Grant / issue / transfer / release sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tcnt        <= '0;
            owner       <= '0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            req_busy    <= '0;
            req_done    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_done    <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner  <= pick_idx;
                        sd_lba <= req_lba[int'(pick_idx)*32 +: 32];
                        sd_rd  <= (pick_op == OP_RD);
                        sd_wr  <= (pick_op == OP_WR);
                        tcnt   <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_busy) begin
                        sd_rd           <= 1'b0;
                        sd_wr           <= 1'b0;
                        req_busy[owner] <= 1'b1;
                        tcnt            <= '0;
                        state           <= ACTIVE;
                    end else if (tcnt == TMO_LAST) begin
                        // Controller never accepted: give the slot to the next requester
                        sd_rd       <= 1'b0;
                        sd_wr       <= 1'b0;
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        tcnt        <= '0;
                        state       <= IDLE;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sd_done) begin
                        req_done[owner] <= 1'b1;
                        state           <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sd_busy) begin
                        req_busy[owner] <= 1'b0;
                        rr_ptr          <= next_ptr;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency steering so strobe and write byte stay aligned with sd_byte_index
    always_comb begin
        req_rd_strobe = '0;
        sd_wr_data    = '0;
        if (state == ACTIVE) begin
            req_rd_strobe[owner] = sd_rd_byte_strobe;
            sd_wr_data           = req_wr_data[int'(owner)*8 +: 8];
        end
    end

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Scoreboard bench for sd_request_arbiter: expected grants and done pulses
// are queued when stimulus is applied and popped when the DUT produces them.
module tb_sd_request_arbiter;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*32-1:0] req_lba = '0;
    logic [N-1:0]    req_rd = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*8-1:0]  req_wr_data = '0;
    logic [N-1:0]    req_busy, req_done, req_rd_strobe;
    logic [31:0]     sd_lba;
    logic            sd_rd, sd_wr;
    logic            sd_busy = 1'b0;
    logic            sd_done = 1'b0;
    logic            sd_rd_byte_strobe = 1'b0;
    logic [8:0]      sd_byte_index = '0;
    logic [7:0]      sd_wr_data;
    logic [1:0]      owner;
    logic            timeout_err;

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] lba;
        logic        wr;
    } gnt_t;

    gnt_t gnt_q[$];
    int   done_q[$];
    int   errors = 0;
    int   checks = 0;
    int   strb_cnt[N] = '{default: 0};
    logic prev_act = 1'b0;

    sd_request_arbiter #(
        .NREQ           (N),
        .ACCEPT_TIMEOUT (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_lba           (req_lba),
        .req_rd            (req_rd),
        .req_wr            (req_wr),
        .req_wr_data       (req_wr_data),
        .req_busy          (req_busy),
        .req_done          (req_done),
        .req_rd_strobe     (req_rd_strobe),
        .sd_lba            (sd_lba),
        .sd_rd             (sd_rd),
        .sd_wr             (sd_wr),
        .sd_busy           (sd_busy),
        .sd_done           (sd_done),
        .sd_rd_byte_strobe (sd_rd_byte_strobe),
        .sd_byte_index     (sd_byte_index),
        .sd_wr_data        (sd_wr_data),
        .owner             (owner),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] wpat(input int i, input int b);
        return 8'(b * 3 + i * 85 + 1);
    endfunction

    task automatic exp_gnt(input int own, input logic [31:0] lba, input logic wr);
        gnt_t g;
        g.own = 2'(own);
        g.lba = lba;
        g.wr  = wr;
        gnt_q.push_back(g);
    endtask

    task automatic set_lba(input int i, input logic [31:0] v);
        req_lba[i*32 +: 32] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_rd = '0;
        req_wr = '0;
        sd_busy = 1'b0;
        sd_done = 1'b0;
        sd_rd_byte_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // SD controller model for one sector; optional reset at byte abort_at,
    // optional re-assertion of req_rd[reassert] during RELEASE
    task automatic sd_xfer(input int own, input int n, input int abort_at, input int reassert);
        int   k;
        logic is_wr;
        k = 0;
        while (!(sd_rd || sd_wr) && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(sd_rd || sd_wr)) begin
            chk("req_wait", 0, 1);
            return;
        end
        is_wr = sd_wr;
        @(posedge clk); #1;
        chk("req_held", {63'b0, sd_rd | sd_wr}, 1);
        sd_busy = 1'b1;
        @(posedge clk); #1;
        chk("busy_own", req_busy, 64'(1 << own));
        chk("req_drop", {63'b0, sd_rd | sd_wr}, 0);
        if (is_wr) req_wr[own] = 1'b0;
        else       req_rd[own] = 1'b0;
        for (int b = 0; b < n; b++) begin
            sd_byte_index = 9'(b);
            for (int i = 0; i < N; i++) req_wr_data[i*8 +: 8] = wpat(i, b);
            sd_rd_byte_strobe = !is_wr;
            if (b == abort_at) begin
                reset = 1'b1;
                sd_busy = 1'b0;
                @(posedge clk); #1;
                chk("abort_outs", {10'b0, sd_rd, sd_wr, sd_lba, req_busy, req_done,
                                   req_rd_strobe, owner, timeout_err, sd_wr_data}, 0);
                reset = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("post_rst_strb", req_rd_strobe, 0);
                end
                sd_rd_byte_strobe = 1'b0;
                return;
            end
            #1;
            if (is_wr) chk("wr_data", sd_wr_data, wpat(own, b));
            @(posedge clk); #1;
        end
        sd_rd_byte_strobe = 1'b0;
        sd_done = 1'b1;
        done_q.push_back(own);
        @(posedge clk); #1;
        sd_done = 1'b0;
        if (reassert >= 0) req_rd[reassert] = 1'b1;
        chk("rel_busy", req_busy, 64'(1 << own));
        @(posedge clk); #1;
        sd_busy = 1'b0;
    endtask

    // Monitor: pop expected grants on each new request, expected done pulses, count strobes
    always @(negedge clk) begin
        if (!reset && (sd_rd || sd_wr) && !prev_act) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexp", {62'b0, sd_wr, sd_rd}, 0);
            end else begin
                chk("gnt_own", owner, gnt_q[0].own);
                chk("gnt_lba", sd_lba, gnt_q[0].lba);
                chk("gnt_op", sd_wr, gnt_q[0].wr);
                void'(gnt_q.pop_front());
            end
        end
        prev_act <= sd_rd | sd_wr;
        if (req_done != '0) begin
            if (done_q.size() == 0) begin
                chk("done_unexp", req_done, 0);
            end else begin
                chk("done_idx", req_done, 64'(1 << done_q[0]));
                void'(done_q.pop_front());
            end
        end
        for (int i = 0; i < N; i++)
            if (req_rd_strobe[i]) strb_cnt[i] <= strb_cnt[i] + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int b0, b1, b2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", sd_rd, 0);
        chk("rst_wr", sd_wr, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_busy", req_busy, 0);
        chk("rst_done", req_done, 0);
        chk("rst_own", owner, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_wdata", sd_wr_data, 0);
        reset = 1'b0;

        // Spurious done/strobes while idle
        for (int i = 0; i < 5; i++) begin
            sd_done = 1'b1;
            sd_rd_byte_strobe = 1'b1;
            @(posedge clk); #1;
            chk("idle_strb", req_rd_strobe, 0);
            chk("idle_req", {sd_rd, sd_wr}, 0);
        end
        sd_done = 1'b0;
        sd_rd_byte_strobe = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", req_busy, 0);
        chk("idle_own", owner, 0);

        // Single 512-byte read for requester 1
        b0 = strb_cnt[0]; b1 = strb_cnt[1]; b2 = strb_cnt[2];
        set_lba(1, 32'h12);
        req_rd[1] = 1'b1;
        exp_gnt(1, 32'h12, 1'b0);
        @(posedge clk); #1;
        chk("gnt_lat", sd_rd, 1);
        sd_xfer(1, 512, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("strb_r1", strb_cnt[1] - b1, 512);
        chk("strb_r0", strb_cnt[0] - b0, 0);
        chk("strb_r2", strb_cnt[2] - b2, 0);

        // Three simultaneous reads after reset; 0 re-requests during its release
        do_reset();
        set_lba(0, 32'h100);
        set_lba(1, 32'h101);
        set_lba(2, 32'h102);
        req_rd = 3'b111;
        exp_gnt(0, 32'h100, 1'b0);
        exp_gnt(1, 32'h101, 1'b0);
        exp_gnt(2, 32'h102, 1'b0);
        exp_gnt(0, 32'h100, 1'b0);
        sd_xfer(0, 8, -1, 0);
        n = 0;
        while (!sd_rd && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("turnaround", n, 2);
        sd_xfer(1, 8, -1, -1);
        sd_xfer(2, 8, -1, -1);
        sd_xfer(0, 8, -1, -1);

        // Requester 2 asks for read and write together
        set_lba(2, 32'h2222);
        req_rd[2] = 1'b1;
        req_wr[2] = 1'b1;
        exp_gnt(2, 32'h2222, 1'b0);
        exp_gnt(2, 32'h2222, 1'b1);
        sd_xfer(2, 16, -1, -1);
        sd_xfer(2, 16, -1, -1);

        // Controller never accepts requester 0; requester 1 is served next
        set_lba(0, 32'h300);
        set_lba(1, 32'h301);
        req_rd[0] = 1'b1;
        req_rd[1] = 1'b1;
        exp_gnt(0, 32'h300, 1'b0);
        exp_gnt(1, 32'h301, 1'b0);
        n = 0;
        while (!sd_rd && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (!timeout_err && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_rd", sd_rd, 0);
        chk("tmo_busy", req_busy, 0);
        req_rd[0] = 1'b0;
        @(posedge clk); #1;
        chk("tmo_pulse", timeout_err, 0);
        sd_xfer(1, 8, -1, -1);

        // Reset during the transfer at byte 200
        b2 = strb_cnt[2];
        set_lba(2, 32'h4444);
        req_rd[2] = 1'b1;
        exp_gnt(2, 32'h4444, 1'b0);
        sd_xfer(2, 300, 200, -1);
        @(posedge clk); #1;
        chk("abort_strb", strb_cnt[2] - b2, 201);
        chk("abort_idle", {sd_rd, sd_wr}, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_q_left", gnt_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
